// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-requester memory arbiter: FSM state
//   encoding, default RAM address slicing and the data width. Also imported
//   by the CPU top so that address slicing stays consistent.
package mem_arbiter_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_LSB_DEF = 3;
    localparam int RAM_AW_DEF   = 14;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   One requester channel of the memory arbiter.
//   valid/we/addr/wdata : request from the requester
//   ready               : request accepted this cycle
//   rvalid/rdata        : one-cycle response (read data or write ack)
//   master modport = requester side, slave modport = arbiter side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              valid;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way winner selection, purely combinational.
//   req[1:0]   : request per requester
//   last_grant : index of the requester granted most recently
//   rr_en      : 1 = round-robin on contention, 0 = requester 0 always wins
//   gnt[1:0]   : one-hot grant, all zero when nothing is requested
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On contention the requester that did not win last time goes next.
            2'b11:   gnt = (rr_en && !last_grant) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates two requesters onto one single-port synchronous RAM.
//   One access per two cycles: grant in IDLE, response in RESP.
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low
//   m0, m1     : requester channels (CPU LSU, loader/DMA)
//   ram_we     : RAM write enable, grant cycle only
//   ram_addr   : RAM word address (winner addr[ADDR_LSB+RAM_AW-1:ADDR_LSB])
//   ram_wdata  : RAM write data
//   ram_rdata  : RAM read data, one cycle after the address
//   busy       : high while in RESP
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | grant a requester combinationally, drive RAM from the winner
//   RESP  | return ram_rdata / write ack to the owner, then back to IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_LSB = ADDR_LSB_DEF,
    parameter int RAM_AW   = RAM_AW_DEF,
    parameter int RR_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      m0,
    mem_arbiter_if.slave      m1,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic RR_ON = (RR_EN != 0);

    state_t     state;
    logic       last_grant;
    logic       owner;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       resp;

    // Requests are only seen in IDLE and out of reset, so ready never
    // appears in RESP or while rst is low.
    assign req = (state == IDLE && rst) ? {m1.valid, m0.valid} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant),
        .rr_en      (RR_ON),
        .gnt        (gnt)
    );

    assign m0.ready = gnt[0];
    assign m1.ready = gnt[1];

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt[0]) begin
            ram_we    = m0.we;
            ram_addr  = m0.addr[ADDR_LSB+RAM_AW-1:ADDR_LSB];
            ram_wdata = m0.wdata;
        end else if (gnt[1]) begin
            ram_we    = m1.we;
            ram_addr  = m1.addr[ADDR_LSB+RAM_AW-1:ADDR_LSB];
            ram_wdata = m1.wdata;
        end
    end

    // Gating with rst keeps every output quiet in the reset cycle itself.
    assign resp      = (state == RESP) && rst;
    assign busy      = resp;
    assign m0.rvalid = resp && !owner;
    assign m1.rvalid = resp && owner;
    assign m0.rdata  = m0.rvalid ? ram_rdata : '0;
    assign m1.rdata  = m1.rvalid ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        state      <= RESP;
                        owner      <= gnt[1];
                        last_grant <= gnt[1];
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int WORDS = 1 << RAM_AW_DEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        s_v0 = 0, s_we0 = 0, s_v1 = 0, s_we1 = 0;
    logic [31:0] s_a0 = 0, s_d0 = 0, s_a1 = 0, s_d1 = 0;

    mem_arbiter_if m0_rr ();
    mem_arbiter_if m1_rr ();
    mem_arbiter_if m0_fp ();
    mem_arbiter_if m1_fp ();

    assign m0_rr.valid = s_v0;  assign m0_rr.we = s_we0; assign m0_rr.addr = s_a0; assign m0_rr.wdata = s_d0;
    assign m1_rr.valid = s_v1;  assign m1_rr.we = s_we1; assign m1_rr.addr = s_a1; assign m1_rr.wdata = s_d1;
    assign m0_fp.valid = s_v0;  assign m0_fp.we = s_we0; assign m0_fp.addr = s_a0; assign m0_fp.wdata = s_d0;
    assign m1_fp.valid = s_v1;  assign m1_fp.we = s_we1; assign m1_fp.addr = s_a1; assign m1_fp.wdata = s_d1;

    logic                  rr_we, fp_we, rr_busy, fp_busy;
    logic [RAM_AW_DEF-1:0] rr_addr, fp_addr;
    logic [31:0]           rr_wd, fp_wd, rr_rd, fp_rd;

    mem_arbiter #(.RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst), .m0(m0_rr), .m1(m1_rr),
        .ram_we(rr_we), .ram_addr(rr_addr), .ram_wdata(rr_wd),
        .ram_rdata(rr_rd), .busy(rr_busy)
    );

    mem_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst), .m0(m0_fp), .m1(m1_fp),
        .ram_we(fp_we), .ram_addr(fp_addr), .ram_wdata(fp_wd),
        .ram_rdata(fp_rd), .busy(fp_busy)
    );

    // Synchronous RAM models, one per DUT; word 2 preloaded with 0xDEADBEEF.
    logic [31:0] mem [2][WORDS];
    bit          mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int d = 0; d < 2; d++)
                for (int w = 0; w < WORDS; w++)
                    mem[d][w] <= (w == 2) ? 32'hDEADBEEF : 32'h0;
            mem_loaded <= 1'b1;
        end else begin
            if (rr_we) mem[0][rr_addr] <= rr_wd;
            if (fp_we) mem[1][fp_addr] <= fp_wd;
            rr_rd <= mem[0][rr_addr];
            fp_rd <= mem[1][fp_addr];
        end
    end

    typedef struct {
        logic        rst;
        logic        v0, we0;
        logic [31:0] a0, d0;
        logic        v1, we1;
        logic [31:0] a1, d1;
        logic [1:0]  g_rr, g_fp;
        logic        busy;
    } vec_t;

    typedef struct {
        logic        port;
        logic        is_wr;
        logic [31:0] data;
        int          due;
    } sb_t;

    vec_t        vt[$];
    sb_t         sbq [2][$];
    logic [31:0] shadow [2][WORDS];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic add(input logic r, input logic v0, input logic we0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic v1, input logic we1,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic [1:0] g_rr, input logic [1:0] g_fp, input logic b);
        vec_t v;
        v.rst = r; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.g_rr = g_rr; v.g_fp = g_fp; v.busy = b;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] t;
        t = a >> ADDR_LSB_DEF;
        return t & ((32'd1 << RAM_AW_DEF) - 32'd1);
    endfunction

    initial begin
        vec_t        v;
        sb_t         e;
        logic [1:0]  eg, a_rdy, a_rv, exp_rv;
        logic        a_we, a_busy, e_we;
        logic [31:0] a_addr, a_wd, a_rd0, a_rd1, e_addr, e_wd, w;
        string       p;
        bit          rr_m1_seen, fp_m1_seen;

        for (int d = 0; d < 2; d++)
            for (int k = 0; k < WORDS; k++)
                shadow[d][k] = (k == 2) ? 32'hDEADBEEF : 32'h0;

        //   rst v0 we0 a0             d0            v1 we1 a1        d1            g_rr   g_fp   busy
        add(0, 1, 0, 32'h10,       0,            0, 0, 0,        0,            2'b00, 2'b00, 0);
        add(0, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 0);
        add(1, 1, 0, 32'h10,       0,            0, 0, 0,        0,            2'b01, 2'b01, 0);
        add(1, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 1);
        add(1, 0, 0, 0,            0,            1, 1, 32'h40,   32'h12345678, 2'b10, 2'b10, 0);
        add(1, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 1);
        add(1, 1, 0, 32'h40,       0,            0, 0, 0,        0,            2'b01, 2'b01, 0);
        add(1, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 1);
        add(1, 0, 0, 0,            0,            1, 0, 32'h0,    0,            2'b10, 2'b10, 0);
        add(1, 1, 0, 32'h10,       0,            0, 0, 0,        0,            2'b00, 2'b00, 1);
        add(1, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 0);
        add(0, 1, 0, 32'h10,       0,            1, 0, 32'h40,   0,            2'b00, 2'b00, 0);
        for (int k = 0; k < 8; k++)
            add(1, 1, 0, 32'h10, 0, 1, 0, 32'h40, 0,
                (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10),
                (k % 2 == 1) ? 2'b00 : 2'b01, (k % 2 == 1));
        add(1, 0, 0, 0,            0,            1, 0, 32'h40,   0,            2'b10, 2'b10, 0);
        add(0, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 0);
        add(1, 1, 0, 32'h10,       0,            1, 0, 32'h40,   0,            2'b01, 2'b01, 0);
        add(1, 1, 0, 32'h10,       0,            1, 0, 32'h40,   0,            2'b00, 2'b00, 1);
        add(1, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 0);
        add(1, 1, 1, 32'hFFFC0018, 32'hA5A55A5A, 0, 0, 0,        0,            2'b01, 2'b01, 0);
        add(1, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 1);
        add(1, 0, 0, 0,            0,            1, 0, 32'h18,   0,            2'b10, 2'b10, 0);
        add(1, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 1);
        add(1, 0, 0, 0,            0,            0, 0, 0,        0,            2'b00, 2'b00, 0);

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            @(negedge clk);
            rst = v.rst;
            s_v0 = v.v0; s_we0 = v.we0; s_a0 = v.a0; s_d0 = v.d0;
            s_v1 = v.v1; s_we1 = v.we1; s_a1 = v.a1; s_d1 = v.d1;
            #3;
            for (int d = 0; d < 2; d++) begin
                p = (d == 0) ? "rr" : "fp";
                if (d == 0) begin
                    a_rdy = {m1_rr.ready, m0_rr.ready}; a_rv = {m1_rr.rvalid, m0_rr.rvalid};
                    a_rd0 = m0_rr.rdata; a_rd1 = m1_rr.rdata;
                    a_we = rr_we; a_addr = 32'(rr_addr); a_wd = rr_wd; a_busy = rr_busy;
                    eg = v.g_rr;
                end else begin
                    a_rdy = {m1_fp.ready, m0_fp.ready}; a_rv = {m1_fp.rvalid, m0_fp.rvalid};
                    a_rd0 = m0_fp.rdata; a_rd1 = m1_fp.rdata;
                    a_we = fp_we; a_addr = 32'(fp_addr); a_wd = fp_wd; a_busy = fp_busy;
                    eg = v.g_fp;
                end
                e_we = 1'b0; e_addr = 32'h0; e_wd = 32'h0;
                if (eg[0]) begin
                    e_we = v.we0; e_addr = word_of(v.a0); e_wd = v.d0;
                end else if (eg[1]) begin
                    e_we = v.we1; e_addr = word_of(v.a1); e_wd = v.d1;
                end
                chk({p, "_ready"},     i, 32'(a_rdy),  32'(eg));
                chk({p, "_ram_we"},    i, 32'(a_we),   32'(e_we));
                chk({p, "_ram_addr"},  i, a_addr,      e_addr);
                chk({p, "_ram_wdata"}, i, a_wd,        e_wd);
                chk({p, "_busy"},      i, 32'(a_busy), 32'(v.busy));

                // A reset drops any response still owed.
                if (!v.rst) sbq[d].delete();
                exp_rv = 2'b00;
                if (sbq[d].size() > 0 && sbq[d][0].due == i) begin
                    e = sbq[d].pop_front();
                    exp_rv[e.port] = 1'b1;
                    if (!e.is_wr)
                        chk({p, "_rdata"}, i, e.port ? a_rd1 : a_rd0, e.data);
                end
                chk({p, "_rvalid"}, i, 32'(a_rv), 32'(exp_rv));

                if (eg != 2'b00) begin
                    e.port  = eg[1];
                    e.is_wr = e_we;
                    e.due   = i + 1;
                    e.data  = shadow[d][e_addr];
                    if (e_we) shadow[d][e_addr] = e_wd;
                    sbq[d].push_back(e);
                end
            end
        end

        // Starvation bound: with last grant on m1, m1 must win within 4 cycles
        // of continuous contention under round-robin; never under fixed priority.
        rr_m1_seen = 1'b0;
        fp_m1_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_v0 = 1; s_we0 = 0; s_a0 = 32'h10;
            s_v1 = 1; s_we1 = 0; s_a1 = 32'h40;
            #3;
            if (m1_rr.ready) rr_m1_seen = 1'b1;
            if (m1_fp.ready) fp_m1_seen = 1'b1;
        end
        chk("rr_m1_grant_within_4", 0, 32'(rr_m1_seen), 32'd1);
        chk("fp_m1_never_granted",  0, 32'(fp_m1_seen), 32'd0);
        @(negedge clk);
        s_v0 = 0; s_v1 = 0;

        chk("rr_sb_empty", 0, 32'(sbq[0].size()), 32'd0);
        chk("fp_sb_empty", 0, 32'(sbq[1].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_LSB, default 3, lowest address bit forwarded to RAM; RAM_AW, default 14, RAM word-address width; RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- m0_valid  in  1  requester 0 (CPU LSU) access request.
- m0_we  in  1  requester 0 write enable.
- m0_addr  in  32  requester 0 byte address.
- m0_wdata  in  32  requester 0 write data.
- m0_ready  out  1  requester 0 request accepted this cycle.
- m0_rvalid  out  1  requester 0 response (read data or write ack).
- m0_rdata  out  32  requester 0 read data.
- m1_valid, m1_we, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata: same directions, widths and meanings for requester 1 (loader/DMA).
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after the address.
- busy  out  1  high while in state RESP.

Function
REQ-003 The FSM SHALL have two states: IDLE and RESP.
REQ-004 In IDLE, when at least one of m0_valid/m1_valid is high, one requester SHALL be granted combinationally: mN_ready=1 for the winner only, and the FSM SHALL go to RESP at the next edge.
REQ-005 A handshake SHALL be mN_valid & mN_ready; a requester SHALL NOT receive ready in RESP.
REQ-006 Arbitration with RR_EN=1: a lone requester wins; on a simultaneous request, the requester not in last_grant wins; last_grant SHALL update on every handshake.
REQ-007 Arbitration with RR_EN=0: requester 0 SHALL always win a simultaneous request.
REQ-008 In the grant cycle, ram_addr SHALL equal winner addr[ADDR_LSB+RAM_AW-1:ADDR_LSB] and ram_wdata SHALL equal winner wdata.
REQ-009 ram_we SHALL equal winner we in the grant cycle only; otherwise it SHALL be 0.
REQ-010 Address bits outside the forwarded range SHALL be ignored; no error signalling.
REQ-011 In RESP, mN_rvalid SHALL be 1 for exactly one cycle, to the requester granted in the previous cycle, for both reads and writes.
REQ-012 In RESP, mN_rdata SHALL equal ram_rdata; the other requester's rvalid SHALL be 0.
REQ-013 RESP SHALL return to IDLE unconditionally. Throughput SHALL be one access per 2 cycles; latency from handshake to rvalid SHALL be 1 cycle.
REQ-014 With RR_EN=1, a continuously requesting master SHALL be granted within 2 grant opportunities (4 cycles).
REQ-015 Inactive outputs SHALL be 0: ready, rvalid, ram_we; ram_addr and ram_wdata SHALL be 0 when nothing is granted.
REQ-016 If a requester drops valid before being granted, no access SHALL occur for it.

Reset
REQ-017 When rst=0 at a clock edge: state SHALL become IDLE, last_grant=1 (requester 0 wins the first contention), and the registered grant owner SHALL be 0.
REQ-018 While rst=0, all outputs SHALL be 0 in the same cycle, with no grant and no RAM write.
REQ-019 A reset asserted during RESP SHALL drop the pending response: no rvalid is issued after reset releases.

Structure
REQ-020 A shared package/header SHALL hold the state encoding (IDLE=0, RESP=1) and the ADDR_LSB and RAM_AW defaults, also used by the CPU top.
REQ-021 The two-way winner selection SHALL be one sub-module, rr_arb2: inputs req[1:0], last_grant, rr_en; output one-hot gnt[1:0].
REQ-022 Only the FSM state, last_grant and grant owner SHALL be registered; the RAM mux SHALL be combinational.

Verification
REQ-023 Reset release, m0 reads addr 0x0000_0010 with RAM word 2 = 0xDEADBEEF -> ram_addr=2 and m0_ready=1 in cycle 0; m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle 1.
REQ-024 m1 writes 0x1234_5678 to 0x0000_0040 -> ram_we=1 and ram_addr=8 for one cycle; m1_rvalid=1 next cycle; a following m0 read of 0x40 returns 0x12345678.
REQ-025 RR_EN=1, both valid continuously for 8 cycles after reset -> grant order m0, m1, m0, m1, with rvalid alternating accordingly.
REQ-026 RR_EN=0, same stimulus -> m0 granted every IDLE cycle; m1_ready stays 0.
REQ-027 rst=0 asserted in the RESP cycle of an m1 read -> m1_rvalid stays 0, busy=0; after release, the first contention grants m0.
REQ-028 m0_valid pulsed in a RESP cycle only -> m0_ready=0, no RAM access, no rvalid.
